// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time,
// and fills the IF/E pipeline register, honouring stalls and redirects.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   REQ     | presenting pc_f to imem, waiting for acceptance
//   WAIT    | request accepted, waiting for the response
//   HOLD    | response captured in hold buffer while decode is stalled
//   DISCARD | stale request outstanding after a redirect; drop its data
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_E,
    output logic [31:0] pc_E,
    output logic        valid_E,
    output logic [6:0]  opcode
);

    typedef enum logic [1:0] {
        REQ     = 2'd0,
        WAIT    = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc_f, pc_f_n;
    logic [31:0] hold_buf, hold_buf_n;
    logic [31:0] inst_E_n, pc_E_n;
    logic        valid_E_n;
    // Registered "out of reset" flag keeps imem_req low through reset without
    // a combinational path from the reset input to the request.
    logic        run;
    logic        accepted;

    assign imem_req  = run && (state == REQ);
    assign imem_addr = pc_f;
    assign accepted  = imem_req && imem_ready;
    assign opcode    = inst_E[6:0];

    // Next-state, next-PC and IF/E register selection; redirect overrides all.
    always_comb begin
        state_n    = state;
        pc_f_n     = pc_f;
        hold_buf_n = hold_buf;
        inst_E_n   = inst_E;
        pc_E_n     = pc_E;
        valid_E_n  = valid_E;

        if (redirect) begin
            pc_f_n    = {redirect_pc[31:2], 2'b00};
            inst_E_n  = NOP_INST;
            valid_E_n = 1'b0;
            case (state)
                REQ:     state_n = accepted ? DISCARD : REQ;
                WAIT:    state_n = imem_rvalid ? REQ : DISCARD;
                HOLD:    state_n = REQ;
                DISCARD: state_n = imem_rvalid ? REQ : DISCARD;
                default: state_n = REQ;
            endcase
        end else begin
            // Bubble by default when not stalled; overwritten on delivery.
            if (!stall) begin
                inst_E_n  = NOP_INST;
                valid_E_n = 1'b0;
            end
            case (state)
                REQ: begin
                    if (accepted) state_n = WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (!stall) begin
                            inst_E_n  = imem_rdata;
                            pc_E_n    = pc_f;
                            valid_E_n = 1'b1;
                            pc_f_n    = pc_f + 32'd4;
                            state_n   = REQ;
                        end else begin
                            hold_buf_n = imem_rdata;
                            state_n    = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        inst_E_n  = hold_buf;
                        pc_E_n    = pc_f;
                        valid_E_n = 1'b1;
                        pc_f_n    = pc_f + 32'd4;
                        state_n   = REQ;
                    end
                end
                DISCARD: begin
                    if (imem_rvalid) state_n = REQ;
                end
                default: state_n = REQ;
            endcase
        end
    end

    // State, PC, hold buffer and IF/E register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= REQ;
            pc_f     <= RESET_PC;
            hold_buf <= 32'd0;
            inst_E   <= NOP_INST;
            pc_E     <= 32'd0;
            valid_E  <= 1'b0;
            run      <= 1'b0;
        end else begin
            state    <= state_n;
            pc_f     <= pc_f_n;
            hold_buf <= hold_buf_n;
            inst_E   <= inst_E_n;
            pc_E     <= pc_E_n;
            valid_E  <= valid_E_n;
            run      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the bench plays instruction memory by hand.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst_E;
    logic [31:0] pc_E;
    logic        valid_E;
    logic [6:0]  opcode;

    int n_run  = 0;
    int n_fail = 0;

    localparam logic [31:0] S_REQ = 32'd0, S_WAIT = 32'd1, S_HOLD = 32'd2, S_DISCARD = 32'd3;
    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_E(inst_E), .pc_E(pc_E), .valid_E(valid_E), .opcode(opcode)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ife(input string tag, input logic [31:0] i, input logic [31:0] p, input logic v);
        chk({tag, ".inst"}, inst_E, i);
        chk({tag, ".pc"}, pc_E, p);
        chk({tag, ".valid"}, {31'd0, valid_E}, {31'd0, v});
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;

        // Reset held two cycles
        tick(); tick();
        chk_ife("rst", NOP, 32'd0, 1'b0);
        chk("rst.opcode", {25'd0, opcode}, 32'h13);
        chk("rst.req", {31'd0, imem_req}, 32'd0);
        chk("rst.pc_f", dut.pc_f, 32'd0);

        // Sequential fetch, response one cycle after acceptance
        reset = 1'b0; imem_ready = 1'b1;
        tick();
        chk("seq.req0", {31'd0, imem_req}, 32'd1);
        chk("seq.addr0", imem_addr, 32'h0);
        tick();
        chk("seq.wait.req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        tick();
        imem_rvalid = 1'b0;
        chk_ife("seq.i0", 32'h0050_0093, 32'h0, 1'b1);
        chk("seq.opcode", {25'd0, opcode}, 32'h13);
        chk("seq.addr1", imem_addr, 32'h4);
        chk("seq.req1", {31'd0, imem_req}, 32'd1);
        tick();
        chk_ife("seq.bubble", NOP, 32'h0, 1'b0);
        imem_rvalid = 1'b1; imem_rdata = 32'h0010_0113;
        tick();
        imem_rvalid = 1'b0;
        chk_ife("seq.i1", 32'h0010_0113, 32'h4, 1'b1);
        chk("seq.addr2", imem_addr, 32'h8);

        // Stall on arrival of the PC 0x8 response, held three cycles
        tick();
        chk_ife("stl.bubble", NOP, 32'h4, 1'b0);
        imem_rvalid = 1'b1; imem_rdata = 32'h0020_8193; stall = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        chk("stl.state", 32'(dut.state), S_HOLD);
        chk_ife("stl.frz1", NOP, 32'h4, 1'b0);
        tick(); tick();
        chk("stl.state3", 32'(dut.state), S_HOLD);
        chk_ife("stl.frz3", NOP, 32'h4, 1'b0);
        chk("stl.req", {31'd0, imem_req}, 32'd0);
        stall = 1'b0;
        tick();
        chk_ife("stl.rel", 32'h0020_8193, 32'h8, 1'b1);
        chk("stl.addr", imem_addr, 32'hC);

        // Fetch 0xC, then redirect while waiting on 0x10
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h0031_0213;
        tick();
        imem_rvalid = 1'b0;
        chk_ife("rw.iC", 32'h0031_0213, 32'hC, 1'b1);
        chk("rw.addr10", imem_addr, 32'h10);
        tick();
        chk("rw.wait", 32'(dut.state), S_WAIT);
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        chk("rw.state", 32'(dut.state), S_DISCARD);
        chk("rw.valid", {31'd0, valid_E}, 32'd0);
        chk("rw.pc_f", dut.pc_f, 32'h100);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        chk_ife("rw.drop", NOP, 32'hC, 1'b0);
        chk("rw.addr", imem_addr, 32'h100);
        chk("rw.req", {31'd0, imem_req}, 32'd1);

        // Backpressure: imem_ready low for four cycles
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp.req", {31'd0, imem_req}, 32'd1);
            chk("bp.addr", imem_addr, 32'h100);
            chk("bp.pc_f", dut.pc_f, 32'h100);
        end
        imem_ready = 1'b1;
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0513;
        tick();
        imem_rvalid = 1'b0; imem_ready = 1'b0;
        chk_ife("bp.i100", 32'h00A0_0513, 32'h100, 1'b1);

        // Redirect together with stall, unaligned target
        redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h203;
        tick();
        redirect = 1'b0; stall = 1'b0;
        chk("rs.pc_f", dut.pc_f, 32'h200);
        chk_ife("rs.bubble", NOP, 32'h100, 1'b0);
        chk("rs.addr", imem_addr, 32'h200);
        chk("rs.req", {31'd0, imem_req}, 32'd1);

        // Redirect in REQ while the stale request is accepted
        imem_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0; imem_ready = 1'b0;
        chk("rq.state", 32'(dut.state), S_DISCARD);
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
        tick();
        imem_rvalid = 1'b0;
        chk("rq.back", 32'(dut.state), S_REQ);
        chk("rq.inst", inst_E, NOP);

        // PC wrap
        chk("wr.addr0", imem_addr, 32'hFFFF_FFFC);
        imem_ready = 1'b1;
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h0010_0093;
        tick();
        imem_rvalid = 1'b0;
        chk_ife("wr.i0", 32'h0010_0093, 32'hFFFF_FFFC, 1'b1);
        chk("wr.addr1", imem_addr, 32'h0);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h0020_0113;
        tick();
        imem_rvalid = 1'b0;
        chk_ife("wr.i1", 32'h0020_0113, 32'h0, 1'b1);

        // Reset mid-transaction overrides stall, redirect and rvalid
        tick();
        chk("mr.wait", 32'(dut.state), S_WAIT);
        reset = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h400;
        imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222;
        tick();
        chk("mr.state", 32'(dut.state), S_REQ);
        chk("mr.pc_f", dut.pc_f, 32'h0);
        chk_ife("mr", NOP, 32'h0, 1'b0);
        chk("mr.req", {31'd0, imem_req}, 32'd0);
        reset = 1'b0; stall = 1'b0; redirect = 1'b0; imem_rvalid = 1'b0;
        tick();
        chk("mr.req1", {31'd0, imem_req}, 32'd1);
        chk("mr.addr1", imem_addr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the three-stage RISC-V pipeline, directly upstream of the decode/controller logic. It owns the program counter and issues one instruction-memory request at a time. It registers each returned instruction into the IF/E pipeline register and exports `opcode` to the controller. It honours load-use stalls from the hazard logic and branch/jump redirects from the execute stage, inserting bubbles (canonical NOP) where required.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP_INST`, 32'h0000_0013, bubble instruction (`addi x0,x0,0`).

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold the IF/E register and the PC.
- `redirect`  in  1  taken branch/jump resolved in E this cycle.
- `redirect_pc`  in  32  target PC; bits [1:0] ignored and treated as 0.
- `imem_req`  out  1  request valid.
- `imem_addr`  out  32  request address, always word aligned.
- `imem_ready`  in  1  request accepted when `imem_req && imem_ready`.
- `imem_rvalid`  in  1  response valid; exactly one response per accepted request.
- `imem_rdata`  in  32  response instruction.
- `inst_E`  out  32  IF/E register: instruction.
- `pc_E`  out  32  IF/E register: PC of `inst_E`.
- `valid_E`  out  1  IF/E register: 1 means real instruction, 0 means bubble.
- `opcode`  out  7  `inst_E[6:0]`, fed to the controller.

## Operation
- Internal state:
  - `pc_f` (32 bits, [1:0]=0)
  - 32-bit hold buffer
  - FSM with states REQ, WAIT, HOLD, DISCARD
- REQ:
  - `imem_req`=1, `imem_addr`=`pc_f`.
  - On `imem_ready`, go to WAIT; otherwise stay.
- WAIT:
  - `imem_req`=0.
  - On `imem_rvalid` with `stall`=0: load `inst_E`=`imem_rdata`, `pc_E`=`pc_f`, `valid_E`=1; `pc_f` += 4; go to REQ.
  - On `imem_rvalid` with `stall`=1: capture `imem_rdata` into the hold buffer; go to HOLD.
- HOLD:
  - `imem_req`=0.
  - When `stall`=0: move the hold buffer into the IF/E register with `pc_E`=`pc_f` and `valid_E`=1; `pc_f` += 4; go to REQ.
- DISCARD:
  - `imem_req`=0.
  - On `imem_rvalid`: drop the data and go to REQ.
- IF/E register:
  - `stall`=1 and no redirect: all fields hold.
  - `stall`=0 and no instruction delivered this cycle: load bubble (`inst_E`=`NOP_INST`, `valid_E`=0). `pc_E` holds its value.
- Redirect has the highest priority and overrides `stall`.
  - `pc_f` is set to `{redirect_pc[31:2],2'b00}`.
  - The IF/E register loads a bubble.
  - Next state by current state:
    - REQ with `imem_ready`=1 (stale request accepted): DISCARD.
    - REQ without `imem_ready`: REQ.
    - WAIT without `imem_rvalid`: DISCARD.
    - WAIT with `imem_rvalid`: data dropped, REQ.
    - HOLD: buffer dropped, REQ.
    - DISCARD without `imem_rvalid`: DISCARD.
    - DISCARD with `imem_rvalid`: REQ.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- At most one request is outstanding. The instruction memory shares `reset` and drops any outstanding response when reset is asserted.

## Timing
- Reset values:
  - state REQ, `pc_f`=`RESET_PC`
  - `inst_E`=`NOP_INST`, `pc_E`=0, `valid_E`=0, `opcode`=7'h13
  - `imem_req`=0 while `reset`=1
- First request: `imem_req`=1 with `imem_addr`=`RESET_PC` in the first cycle after `reset` deasserts.
- Latency: with response N cycles after acceptance, `inst_E` updates on the edge at which `imem_rvalid` is sampled.
- Throughput (`imem_ready`=1, N=1): one instruction per 2 cycles; the intervening cycle holds a bubble.
- `imem_req` and `imem_addr` are decoded from registered state and `pc_f` only, with no input-to-output combinational path.
- `opcode` is a pure slice of `inst_E`.
- Reset asserted mid-transaction: all state returns to reset values on that edge, regardless of `stall`, `redirect` or `imem_rvalid`.

## Test plan
- **Reset and sequential fetch:** assert `reset` 2 cycles, then `imem_ready`=1 with response 1 cycle later, words 0x00500093, 0x00100113. Expect `imem_addr` 0x0 then 0x4. Expect `inst_E`/`pc_E` = 0x00500093/0x0, then 0x00100113/0x4, with bubbles (`valid_E`=0, `inst_E`=0x13) in between.
- **Stall on arrival:** `stall`=1 in the cycle the response for PC 0x8 arrives, held 3 cycles. Expect `inst_E` frozen and state HOLD. On release, `pc_E`=0x8 loads and the next request is 0xC.
- **Redirect in WAIT:** redirect to 0x100 while waiting on PC 0x10; the response arrives 2 cycles later with data 0xDEADBEEF. Expect that data never reaches `inst_E`, next `imem_addr`=0x100, and `valid_E`=0 after the redirect edge.
- **Redirect with stall:** `redirect`=1 and `stall`=1 to 0x203. Expect `pc_f`=0x200, a bubble loaded despite the stall, and the next request at 0x200.
- **PC wrap:** redirect to 0xFFFFFFFC and fetch two words. Expect `pc_E` 0xFFFFFFFC then 0x00000000.
- **Backpressure:** `imem_ready`=0 for 4 cycles. Expect `imem_req`=1 and `imem_addr` stable throughout, and no `pc_f` change.
